// File: rtl/test_axis_tx_gen_pkg.sv
// Shared types and helpers for the AXI-Stream test frame generator.
// Contents: FSM state encoding, default beat width in bytes, tkeep mask builder.
// Imported by test_axis_tx_gen; no logic of its own.
package eth_test_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam int DEF_AXIS_DATA_WIDTH = 64;
    localparam int BYTES               = DEF_AXIS_DATA_WIDTH / 8;

    // Widest beat the mask helper supports (1024-bit tdata); callers truncate.
    localparam int MAX_BYTES = 128;

    // Low 'remaining' bits set, saturating at all ones.
    function automatic logic [MAX_BYTES-1:0] keep_mask(input logic [31:0] remaining);
        logic [MAX_BYTES-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_BYTES; i++) begin
            m[i] = (32'(i) < remaining);
        end
        return m;
    endfunction

endpackage

// File: rtl/test_axis_tx_gen_if.sv
// AXI-Stream bus bundle used between the test generator and its sink.
// Ports: tdata/tkeep/tvalid/tlast from master, tready from slave.
// Pure wiring; master and slave modports fix the directions.
interface test_axis_tx_gen_if #(
    parameter int DATA_W = 64
) ();
    logic [DATA_W-1:0]   tdata;
    logic [DATA_W/8-1:0] tkeep;
    logic                tvalid;
    logic                tlast;
    logic                tready;

    modport master (output tdata, output tkeep, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tkeep, input tvalid, input tlast, output tready);
endinterface

// File: rtl/test_axis_tx_gen.sv
// Test AXI-Stream frame generator: frames of frame_len bytes, byte-counter payload, ifg_len idle gap.
// Latency: tvalid rises one clock after gen_en is seen in IDLE; all outputs registered.
// Backpressure: beat held stable while tready=0; tvalid never dropped before the transfer.
// Ports: clk, rstn (async active-low), gen_en, frame_len, ifg_len, tx_axis (master), frame_cnt, busy.
module test_axis_tx_gen
    import eth_test_pkg::*;
#(
    parameter int AXIS_DATA_WIDTH = 64,
    parameter int FRAME_LEN_W     = 16,
    parameter int FRAME_CNT_W     = 32
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   gen_en,
    input  logic [FRAME_LEN_W-1:0] frame_len,
    input  logic [7:0]             ifg_len,
    test_axis_tx_gen_if.master     tx_axis,
    output logic [FRAME_CNT_W-1:0] frame_cnt,
    output logic                   busy
);

    localparam int BEAT_BYTES = AXIS_DATA_WIDTH / 8;
    // One extra bit so off never wraps at the largest frame_len.
    localparam int OFF_W      = FRAME_LEN_W + 1;

    state_t                     state;
    state_t                     state_nxt;
    logic [FRAME_LEN_W-1:0]     len_q;
    logic [OFF_W-1:0]           off;
    logic [7:0]                 gap_cnt;

    logic                       tvalid_q;
    logic                       tlast_q;
    logic [AXIS_DATA_WIDTH-1:0] tdata_q;
    logic [BEAT_BYTES-1:0]      tkeep_q;

    logic                       xfer;
    logic                       start;
    logic                       advance;
    logic                       finish;
    logic [OFF_W-1:0]           beat_off;
    logic [FRAME_LEN_W-1:0]     beat_len;
    logic [OFF_W-1:0]           beat_rem;
    logic [BEAT_BYTES-1:0]      beat_keep;
    logic [AXIS_DATA_WIDTH-1:0] beat_dat;
    logic                       beat_last;

    assign xfer = tvalid_q & tx_axis.tready;

    assign tx_axis.tvalid = tvalid_q;
    assign tx_axis.tlast  = tlast_q;
    assign tx_axis.tdata  = tdata_q;
    assign tx_axis.tkeep  = tkeep_q;

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (gen_en && (frame_len != '0)) state_nxt = SEND;
            SEND: if (xfer && tlast_q) state_nxt = (ifg_len != 8'd0) ? GAP : IDLE;
            GAP:  if (gap_cnt <= 8'd1) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic: contents of the beat to present after the coming edge.
    // On launch the beat is built from the live frame_len at offset 0; otherwise
    // from len_q at the offset following the beat now on the bus.
    always_comb begin
        start     = (state == IDLE) && (state_nxt == SEND);
        advance   = (state == SEND) && xfer && !tlast_q;
        finish    = (state == SEND) && xfer && tlast_q;
        beat_off  = start ? '0 : off + OFF_W'(BEAT_BYTES);
        beat_len  = start ? frame_len : len_q;
        beat_rem  = OFF_W'(beat_len) - beat_off;
        beat_keep = BEAT_BYTES'(keep_mask(32'(beat_rem)));
        beat_last = (beat_rem <= OFF_W'(BEAT_BYTES));
        beat_dat  = '0;
        for (int k = 0; k < BEAT_BYTES; k++) begin
            if (beat_keep[k]) beat_dat[8*k +: 8] = beat_off[7:0] + 8'(k);
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            len_q     <= '0;
            off       <= '0;
            gap_cnt   <= '0;
            tvalid_q  <= 1'b0;
            tlast_q   <= 1'b0;
            tdata_q   <= '0;
            tkeep_q   <= '0;
            frame_cnt <= '0;
            busy      <= 1'b0;
        end else begin
            if (start) begin
                len_q <= frame_len;
                off   <= '0;
            end else if (advance) begin
                off <= beat_off;
            end

            if (start || advance) begin
                tvalid_q <= 1'b1;
                tdata_q  <= beat_dat;
                tkeep_q  <= beat_keep;
                tlast_q  <= beat_last;
            end else if (finish) begin
                tvalid_q <= 1'b0;
                tdata_q  <= '0;
                tkeep_q  <= '0;
                tlast_q  <= 1'b0;
            end

            // gap_cnt is loaded as the frame ends; GAP exits when it reaches 1.
            if (finish) begin
                frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
                gap_cnt   <= ifg_len;
            end else if (state == GAP) begin
                gap_cnt <= gap_cnt - 8'd1;
            end

            busy <= (state_nxt != IDLE);
        end
    end

endmodule

// File: tb/tb_test_axis_tx_gen.sv
// Scoreboard bench for test_axis_tx_gen (64-bit data).
// Expected beats are queued when a frame is requested and compared on every valid cycle.
// Gap, frame count, backpressure stability and async reset are also checked.
module tb_test_axis_tx_gen;

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
    } beat_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic        gen_en;
    logic [15:0] frame_len;
    logic [7:0]  ifg_len;
    logic [31:0] frame_cnt;
    logic        busy;

    test_axis_tx_gen_if #(.DATA_W(64)) tx_axis ();

    test_axis_tx_gen #(
        .AXIS_DATA_WIDTH(64),
        .FRAME_LEN_W    (16),
        .FRAME_CNT_W    (32)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .gen_en   (gen_en),
        .frame_len(frame_len),
        .ifg_len  (ifg_len),
        .tx_axis  (tx_axis),
        .frame_cnt(frame_cnt),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    beat_t q[$];
    int    n_cmp = 0;
    int    n_err = 0;
    int    xfer_cnt = 0;
    int    gap_meas = 0;
    int    gap_run = 0;
    bit    gap_arm = 1'b0;
    bit    rdy_mode = 1'b0;
    int    rdy_idx = 0;
    int    exp_frames = 0;
    int    base;
    logic  rdy_pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference beats: byte k of offset off is (off+k) mod 256, unused bytes zero.
    task automatic push_frame(input int len);
        for (int off = 0; off < len; off += 8) begin
            beat_t b;
            b = '0;
            for (int k = 0; k < 8; k++) begin
                if (off + k < len) begin
                    b.k[k]        = 1'b1;
                    b.d[8*k +: 8] = 8'((off + k) % 256);
                end
            end
            b.l = (len - off <= 8);
            q.push_back(b);
        end
    endtask

    // Compares every presented beat against the queue head (so stalls must hold
    // the beat) and pops on transfer; also measures tvalid-low gaps between frames.
    task automatic monitor();
        forever begin
            @(negedge clk);
            if (rstn && tx_axis.tvalid) begin
                if (gap_arm) begin
                    gap_meas = gap_run;
                    gap_arm  = 1'b0;
                end
                if (q.size() == 0) begin
                    chk("spurious_beat", 64'(tx_axis.tvalid), 64'd0);
                end else begin
                    chk("tdata", tx_axis.tdata, q[0].d);
                    chk("tkeep", 64'(tx_axis.tkeep), 64'(q[0].k));
                    chk("tlast", 64'(tx_axis.tlast), 64'(q[0].l));
                    if (tx_axis.tready) begin
                        void'(q.pop_front());
                        xfer_cnt++;
                    end
                end
                if (tx_axis.tready && tx_axis.tlast) begin
                    gap_arm = 1'b1;
                    gap_run = 0;
                end
            end else if (rstn && gap_arm) begin
                gap_run++;
            end
        end
    endtask

    task automatic ready_drv();
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode) begin
                tx_axis.tready = rdy_pat[rdy_idx];
                rdy_idx = (rdy_idx + 1) % 6;
            end else begin
                tx_axis.tready = 1'b1;
            end
        end
    endtask

    task automatic wait_tvalid(input int lim);
        int n = 0;
        while (!tx_axis.tvalid && n < lim) begin
            @(posedge clk); #1; n++;
        end
        chk("start_seen", 64'(tx_axis.tvalid), 64'd1);
    endtask

    task automatic wait_xfers(input int target, input int lim);
        int n = 0;
        while (xfer_cnt < target && n < lim) begin
            @(posedge clk); #1; n++;
        end
        chk("xfer_reached", 64'(xfer_cnt >= target), 64'd1);
    endtask

    task automatic wait_done(input int lim);
        int n = 0;
        while ((busy || tx_axis.tvalid) && n < lim) begin
            @(posedge clk); #1; n++;
        end
        chk("done_busy", 64'(busy), 64'd0);
    endtask

    task automatic finish_checks();
        chk("frame_cnt", 64'(frame_cnt), 64'(exp_frames));
        chk("q_empty", 64'(q.size()), 64'd0);
        repeat (10) @(posedge clk);
        #1;
        chk("idle_tvalid", 64'(tx_axis.tvalid), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);
    endtask

    // One frame; gen_en dropped once the frame has started (or after drop_after beats).
    task automatic run_one(input int len, input int ifg, input int drop_after);
        int b0;
        b0 = xfer_cnt;
        push_frame(len);
        frame_len = 16'(len);
        ifg_len   = 8'(ifg);
        gen_en    = 1'b1;
        if (drop_after == 0) wait_tvalid(20);
        else                 wait_xfers(b0 + drop_after, 400);
        gen_en = 1'b0;
        exp_frames++;
        wait_done(1000);
        finish_checks();
    endtask

    // Two back-to-back frames; checks the tvalid-low gap between them.
    task automatic run_two(input int len, input int ifg);
        int n = 0;
        push_frame(len);
        push_frame(len);
        frame_len = 16'(len);
        ifg_len   = 8'(ifg);
        gen_en    = 1'b1;
        while (!(frame_cnt == 32'(exp_frames + 1) && tx_axis.tvalid) && n < 400) begin
            @(posedge clk); #1; n++;
        end
        chk("second_start", 64'(tx_axis.tvalid), 64'd1);
        gen_en = 1'b0;
        exp_frames += 2;
        wait_done(1000);
        finish_checks();
        chk("gap_cycles", 64'(gap_meas), 64'(ifg + 1));
    endtask

    initial begin
        rstn           = 1'b0;
        gen_en         = 1'b0;
        frame_len      = '0;
        ifg_len        = '0;
        tx_axis.tready = 1'b1;
        fork
            monitor();
            ready_drv();
        join_none

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_tvalid", 64'(tx_axis.tvalid), 64'd0);
        chk("rst_tlast", 64'(tx_axis.tlast), 64'd0);
        chk("rst_tdata", tx_axis.tdata, 64'd0);
        chk("rst_tkeep", 64'(tx_axis.tkeep), 64'd0);
        chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        rstn = 1'b1;

        // frame_len = 0 never starts a frame
        @(posedge clk); #1;
        gen_en = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("len0_busy", 64'(busy), 64'd0);
        chk("len0_tvalid", 64'(tx_axis.tvalid), 64'd0);
        gen_en = 1'b0;
        @(posedge clk); #1;

        // 64-byte frames back to back, no gap
        run_two(64, 0);

        // Partial final beat
        run_one(13, 0, 0);

        // 300 bytes under backpressure: wraps at 256, 38 beats, last keep 0x0F
        rdy_idx  = 0;
        rdy_mode = 1'b1;
        base     = xfer_cnt;
        run_one(300, 0, 0);
        chk("beats300", 64'(xfer_cnt - base), 64'd38);
        rdy_mode = 1'b0;
        @(posedge clk); #1;

        // gen_en dropped during beat 3: frame still completes, nothing follows
        run_one(64, 0, 2);

        // Programmable gap
        run_two(64, 5);

        // Async reset during beat 4
        base = xfer_cnt;
        push_frame(64);
        frame_len = 16'd64;
        ifg_len   = 8'd0;
        gen_en    = 1'b1;
        wait_xfers(base + 3, 100);
        #1;
        rstn = 1'b0;
        #1;
        chk("arst_tvalid", 64'(tx_axis.tvalid), 64'd0);
        chk("arst_frame_cnt", 64'(frame_cnt), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_tkeep", 64'(tx_axis.tkeep), 64'd0);
        q.delete();
        exp_frames = 0;
        @(posedge clk); #2;
        push_frame(64);
        rstn = 1'b1;
        @(posedge clk); #1;
        wait_tvalid(20);
        gen_en = 1'b0;
        exp_frames = 1;
        wait_done(1000);
        finish_checks();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
